// File: rtl/cpu_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// cpu_multicycle_sequencer
//   Multi-cycle control sequencer for the reduced RV32 core. Holds the PC and
//   instruction register and walks each instruction through
//   FETCH -> DECODE -> EXECUTE -> (MEM) -> (WB), talking to variable-latency
//   instruction/data memories with req/ack. Counts retired instructions and
//   halts (sticky) on ECALL, an illegal instruction or a misaligned target.
//
// Handshake: a req output is raised in its state and held, unchanged, until
//   the matching ack is seen high at a rising edge; that edge completes the
//   transfer. An ack seen while the matching req is low has no effect.
//
// Ports
//   clk, reset            clock; synchronous active-low reset
//   imem_req/addr/rdata/ack  instruction fetch port (addr = pc)
//   dmem_req/we/ack       data access port (we=1 store, 0 load)
//   instr, opcode, func3  instruction register and its decoded fields
//   alu_flag              ALU zero flag (used in EXECUTE for branches)
//   branch_target         pc + B-immediate from the datapath
//   jump_target           pc + J-immediate from the datapath
//   alu_src_imm           ALU operand B selects the immediate
//   reg_write_en          register-file write strobe (WB only)
//   write_mux_sel         WB source: 00 ALU, 01 memory, 10 pc+4
//   pc                    current program counter
//   retire                one-cycle pulse on the last cycle of an instruction
//   instret               retired-instruction count (wraps)
//   halted, fault         sticky halt flag and cause (00 ECALL, 01 illegal,
//                         10 misaligned target)
//   state_dbg             current FSM state encoding
// ---------------------------------------------------------------------------
module cpu_multicycle_sequencer #(
  parameter int              XLEN     = 32,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int              CNT_W    = 32
) (
  input  logic             clk,
  input  logic             reset,
  output logic             imem_req,
  output logic [XLEN-1:0]  imem_addr,
  input  logic [31:0]      imem_rdata,
  input  logic             imem_ack,
  output logic             dmem_req,
  output logic             dmem_we,
  input  logic             dmem_ack,
  output logic [31:0]      instr,
  output logic [6:0]       opcode,
  output logic [2:0]       func3,
  input  logic             alu_flag,
  input  logic [XLEN-1:0]  branch_target,
  input  logic [XLEN-1:0]  jump_target,
  output logic             alu_src_imm,
  output logic             reg_write_en,
  output logic [1:0]       write_mux_sel,
  output logic [XLEN-1:0]  pc,
  output logic             retire,
  output logic [CNT_W-1:0] instret,
  output logic             halted,
  output logic [1:0]       fault,
  output logic [2:0]       state_dbg
);

  typedef enum logic [2:0] {
    S_FETCH   = 3'd0,
    S_DECODE  = 3'd1,
    S_EXECUTE = 3'd2,
    S_MEM     = 3'd3,
    S_WB      = 3'd4,
    S_HALT    = 3'd5
  } state_t;

  localparam logic [6:0] OP_R      = 7'b0110011;
  localparam logic [6:0] OP_I      = 7'b0010011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_ECALL  = 7'b1110011;

  state_t           state, state_nx;
  logic [XLEN-1:0]  pc_nx, pc_plus4, commit_pc;
  logic [1:0]       fault_nx;
  logic             instr_we, commit_req, retire_c;
  logic             imem_req_c, dmem_req_c, dmem_we_c, reg_write_c, alu_imm_c;
  logic [1:0]       wb_sel_c;
  logic             is_r, is_i, is_load, is_store, is_branch, is_jal, is_ecall;
  logic             branch_ok, illegal, branch_taken;

  assign opcode    = instr[6:0];
  assign func3     = instr[14:12];
  assign is_r      = (opcode == OP_R);
  assign is_i      = (opcode == OP_I);
  assign is_load   = (opcode == OP_LOAD);
  assign is_store  = (opcode == OP_STORE);
  assign is_branch = (opcode == OP_BRANCH);
  assign is_jal    = (opcode == OP_JAL);
  assign is_ecall  = (opcode == OP_ECALL);
  // Only BEQ (000) and BNE (001) are implemented branch conditions.
  assign branch_ok = (func3 == 3'b000) || (func3 == 3'b001);
  assign illegal   = !(is_r || is_i || is_load || is_store || (is_branch && branch_ok)
                       || is_jal || is_ecall);
  // alu_flag is the zero flag: BEQ takes on zero, BNE on non-zero.
  assign branch_taken = (func3 == 3'b000) ? alu_flag : !alu_flag;
  assign pc_plus4     = pc + XLEN'(4);

  always_comb begin
    state_nx    = state;
    pc_nx       = pc;
    fault_nx    = fault;
    instr_we    = 1'b0;
    commit_req  = 1'b0;
    commit_pc   = pc_plus4;
    retire_c    = 1'b0;
    imem_req_c  = 1'b0;
    dmem_req_c  = 1'b0;
    dmem_we_c   = 1'b0;
    reg_write_c = 1'b0;
    alu_imm_c   = 1'b0;
    wb_sel_c    = 2'b00;

    case (state)
      S_FETCH: begin
        imem_req_c = 1'b1;
        if (imem_ack) begin
          instr_we = 1'b1;
          state_nx = S_DECODE;
        end
      end
      S_DECODE: begin
        if (illegal) begin
          state_nx = S_HALT;
          fault_nx = 2'b01;
        end else if (is_ecall) begin
          state_nx = S_HALT;
          fault_nx = 2'b00;
        end else begin
          state_nx = S_EXECUTE;
        end
      end
      S_EXECUTE: begin
        alu_imm_c = is_i || is_load || is_store;
        if (is_branch) begin
          commit_req = 1'b1;
          commit_pc  = branch_taken ? branch_target : pc_plus4;
        end else if (is_load || is_store) begin
          state_nx = S_MEM;
        end else begin
          state_nx = S_WB;
        end
      end
      S_MEM: begin
        alu_imm_c  = 1'b1;
        dmem_req_c = 1'b1;
        dmem_we_c  = is_store;
        if (dmem_ack) begin
          if (is_store) begin
            commit_req = 1'b1;
            commit_pc  = pc_plus4;
          end else begin
            state_nx = S_WB;
          end
        end
      end
      S_WB: begin
        alu_imm_c  = is_i || is_load;
        wb_sel_c   = is_load ? 2'b01 : (is_jal ? 2'b10 : 2'b00);
        commit_req = 1'b1;
        commit_pc  = is_jal ? jump_target : pc_plus4;
      end
      default: begin
        state_nx = S_HALT;
      end
    endcase

    // Shared end-of-instruction path: a misaligned next PC halts instead of
    // retiring, leaving PC and the register file untouched.
    if (commit_req) begin
      if (commit_pc[1:0] != 2'b00) begin
        state_nx = S_HALT;
        fault_nx = 2'b10;
      end else begin
        pc_nx       = commit_pc;
        retire_c    = 1'b1;
        reg_write_c = (state == S_WB);
        state_nx    = S_FETCH;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state   <= S_FETCH;
      pc      <= RESET_PC;
      instr   <= '0;
      instret <= '0;
      fault   <= 2'b00;
    end else begin
      state <= state_nx;
      pc    <= pc_nx;
      fault <= fault_nx;
      if (instr_we) instr <= imem_rdata;
      if (retire_c) instret <= instret + CNT_W'(1);
    end
  end

  // While reset is held every request and strobe is forced low so that an
  // in-flight memory access is dropped immediately.
  assign imem_req      = reset && imem_req_c;
  assign dmem_req      = reset && dmem_req_c;
  assign dmem_we       = reset && dmem_we_c;
  assign reg_write_en  = reset && reg_write_c;
  assign retire        = reset && retire_c;
  assign alu_src_imm   = reset && alu_imm_c;
  assign write_mux_sel = reset ? wb_sel_c : 2'b00;
  assign imem_addr     = pc;
  assign halted        = (state == S_HALT);
  assign state_dbg     = state;

endmodule

// File: tb/tb_cpu_multicycle_sequencer.sv
// ---------------------------------------------------------------------------
// tb_cpu_multicycle_sequencer
//   Directed bench for cpu_multicycle_sequencer. Inputs change 2 time units
//   after a rising edge, outputs are sampled 1 unit later. Memories are
//   modelled inline: imem acks in the first cycle of each instruction, dmem
//   acks after a per-instruction number of waiting cycles.
// ---------------------------------------------------------------------------
module tb_cpu_multicycle_sequencer;

  localparam logic [2:0] ST_FETCH = 3'd0;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic [31:0] imem_rdata;
  logic        imem_ack;
  logic        dmem_req;
  logic        dmem_we;
  logic        dmem_ack;
  logic [31:0] instr;
  logic [6:0]  opcode;
  logic [2:0]  func3;
  logic        alu_flag;
  logic [31:0] branch_target;
  logic [31:0] jump_target;
  logic        alu_src_imm;
  logic        reg_write_en;
  logic [1:0]  write_mux_sel;
  logic [31:0] pc;
  logic        retire;
  logic [31:0] instret;
  logic        halted;
  logic [1:0]  fault;
  logic [2:0]  state_dbg;

  int n_vec = 0;
  int n_err = 0;

  // Per-instruction observations filled in by run_instr.
  int          retire_cyc, halt_cyc, n_imreq, n_dreq, n_rw, n_idle_req;
  logic        we_seen, imm_seen, done;
  logic [1:0]  sel_seen;

  cpu_multicycle_sequencer #(.XLEN(32), .RESET_PC(32'h0), .CNT_W(32)) dut (
    .clk(clk), .reset(reset),
    .imem_req(imem_req), .imem_addr(imem_addr), .imem_rdata(imem_rdata), .imem_ack(imem_ack),
    .dmem_req(dmem_req), .dmem_we(dmem_we), .dmem_ack(dmem_ack),
    .instr(instr), .opcode(opcode), .func3(func3),
    .alu_flag(alu_flag), .branch_target(branch_target), .jump_target(jump_target),
    .alu_src_imm(alu_src_imm), .reg_write_en(reg_write_en), .write_mux_sel(write_mux_sel),
    .pc(pc), .retire(retire), .instret(instret), .halted(halted), .fault(fault),
    .state_dbg(state_dbg)
  );

  // clock
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp)
      else begin
        n_err++;
        $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  // Starts in a FETCH cycle; runs until retire or halt (bounded).
  task automatic run_instr(input logic [31:0] word, input int dly, input logic flag,
                           input logic [31:0] bt, input logic [31:0] jt);
    int cyc;
    cyc = 0; retire_cyc = 0; halt_cyc = 0; n_imreq = 0; n_dreq = 0; n_rw = 0;
    we_seen = 1'b0; imm_seen = 1'b0; sel_seen = 2'b00; done = 1'b0;
    alu_flag = flag; branch_target = bt; jump_target = jt; imem_rdata = word;
    while (!done && cyc < 20) begin
      cyc++;
      imem_ack = (cyc == 1);
      dmem_ack = dmem_req && (n_dreq == dly);
      #1;
      if (imem_req) n_imreq++;
      if (dmem_req) begin
        n_dreq++;
        if (dmem_we) we_seen = 1'b1;
      end
      if (alu_src_imm) imm_seen = 1'b1;
      if (reg_write_en) begin
        n_rw++;
        sel_seen = write_mux_sel;
      end
      if (retire) begin
        retire_cyc = cyc;
        done = 1'b1;
      end
      if (halted) begin
        halt_cyc = cyc;
        done = 1'b1;
      end
      @(posedge clk);
      #2;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
    chk("bounded_completion", {31'b0, done}, 32'd1);
  endtask

  // Idle cycles with both acks forced high: counts any request raised.
  task automatic idle(input int n);
    n_idle_req = 0;
    imem_ack = 1'b1;
    dmem_ack = 1'b1;
    for (int i = 0; i < n; i++) begin
      #1;
      if (imem_req || dmem_req || reg_write_en || retire) n_idle_req++;
      @(posedge clk);
      #2;
    end
    imem_ack = 1'b0;
    dmem_ack = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b0;
    tick();
    reset = 1'b1;
  endtask

  initial begin
    reset = 1'b0; imem_rdata = '0; imem_ack = 1'b0; dmem_ack = 1'b0;
    alu_flag = 1'b0; branch_target = '0; jump_target = '0;

    // Reset state, checked while reset is still held.
    tick();
    tick();
    #1;
    chk("rst_imem_req", {31'b0, imem_req}, 32'd0);
    chk("rst_pc", pc, 32'h0);
    chk("rst_instret", instret, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_fault", {30'b0, fault}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_state", {29'b0, state_dbg}, {29'b0, ST_FETCH});
    reset = 1'b1;
    #1;
    chk("fetch_req_after_rst", {31'b0, imem_req}, 32'd1);

    // ADD x3,x1,x2
    run_instr(32'h002081B3, 0, 1'b0, 32'h0, 32'h0);
    chk("add_latency", retire_cyc, 32'd4);
    chk("add_imem_req_cycles", n_imreq, 32'd1);
    chk("add_reg_writes", n_rw, 32'd1);
    chk("add_wb_sel", {30'b0, sel_seen}, 32'd0);
    chk("add_imm", {31'b0, imm_seen}, 32'd0);
    chk("add_pc", pc, 32'h4);
    chk("add_instret", instret, 32'd1);

    // LW x1,0(x2) with dmem ack after 3 waiting cycles
    run_instr(32'h00012083, 3, 1'b0, 32'h0, 32'h0);
    chk("lw_latency", retire_cyc, 32'd8);
    chk("lw_dmem_req_cycles", n_dreq, 32'd4);
    chk("lw_we", {31'b0, we_seen}, 32'd0);
    chk("lw_wb_sel", {30'b0, sel_seen}, 32'd1);
    chk("lw_imm", {31'b0, imm_seen}, 32'd1);
    chk("lw_pc", pc, 32'h8);
    chk("lw_instret", instret, 32'd2);

    // SW x1,0(x2), same-cycle ack
    run_instr(32'h00112023, 0, 1'b0, 32'h0, 32'h0);
    chk("sw_latency", retire_cyc, 32'd4);
    chk("sw_we", {31'b0, we_seen}, 32'd1);
    chk("sw_reg_writes", n_rw, 32'd0);
    chk("sw_pc", pc, 32'hC);
    chk("sw_instret", instret, 32'd3);

    // BEQ taken
    run_instr(32'h00000063, 0, 1'b1, 32'h40, 32'h0);
    chk("beq_latency", retire_cyc, 32'd3);
    chk("beq_reg_writes", n_rw, 32'd0);
    chk("beq_pc", pc, 32'h40);
    chk("beq_instret", instret, 32'd4);

    // BNE with zero flag set: not taken
    run_instr(32'h00001063, 0, 1'b1, 32'h80, 32'h0);
    chk("bne_latency", retire_cyc, 32'd3);
    chk("bne_pc", pc, 32'h44);
    chk("bne_func3", {29'b0, func3}, 32'd1);
    chk("bne_opcode", {25'b0, opcode}, 32'h63);
    chk("bne_instret", instret, 32'd5);

    // ADDI x1,x0,1
    run_instr(32'h00100093, 0, 1'b0, 32'h0, 32'h0);
    chk("addi_latency", retire_cyc, 32'd4);
    chk("addi_imm", {31'b0, imm_seen}, 32'd1);
    chk("addi_wb_sel", {30'b0, sel_seen}, 32'd0);
    chk("addi_pc", pc, 32'h48);

    // JAL aligned
    run_instr(32'h0000006F, 0, 1'b0, 32'h0, 32'h100);
    chk("jal_latency", retire_cyc, 32'd4);
    chk("jal_wb_sel", {30'b0, sel_seen}, 32'd2);
    chk("jal_pc", pc, 32'h100);
    chk("jal_instret", instret, 32'd7);

    // JAL to misaligned target
    run_instr(32'h0000006F, 0, 1'b0, 32'h0, 32'h102);
    chk("jalmis_no_retire", retire_cyc, 32'd0);
    chk("jalmis_halt_cyc", halt_cyc, 32'd5);
    chk("jalmis_reg_writes", n_rw, 32'd0);
    chk("jalmis_fault", {30'b0, fault}, 32'd2);
    chk("jalmis_pc", pc, 32'h100);
    chk("jalmis_instret", instret, 32'd7);
    idle(3);
    chk("halt_no_requests", n_idle_req, 32'd0);
    chk("halt_sticky", {31'b0, halted}, 32'd1);

    // ECALL
    do_reset();
    run_instr(32'h00000073, 0, 1'b0, 32'h0, 32'h0);
    chk("ecall_halt_cyc", halt_cyc, 32'd3);
    chk("ecall_fault", {30'b0, fault}, 32'd0);
    chk("ecall_instret", instret, 32'd0);

    // Illegal branch func3
    do_reset();
    run_instr(32'h00002063, 0, 1'b0, 32'h0, 32'h0);
    chk("badbr_halted", {31'b0, halted}, 32'd1);
    chk("badbr_fault", {30'b0, fault}, 32'd1);

    // Illegal opcode 0x7F, then a single reset edge
    do_reset();
    run_instr(32'h0000007F, 0, 1'b0, 32'h0, 32'h0);
    chk("ill_halted", {31'b0, halted}, 32'd1);
    chk("ill_fault", {30'b0, fault}, 32'd1);
    chk("ill_instret", instret, 32'd0);
    idle(3);
    chk("ill_no_requests", n_idle_req, 32'd0);
    do_reset();
    #1;
    chk("ill_rst_pc", pc, 32'h0);
    chk("ill_rst_halted", {31'b0, halted}, 32'd0);
    chk("ill_rst_fault", {30'b0, fault}, 32'd0);
    chk("ill_rst_state", {29'b0, state_dbg}, {29'b0, ST_FETCH});
    chk("ill_rst_imem_req", {31'b0, imem_req}, 32'd1);

    // Reset while a load waits in MEM; the late dmem ack must be ignored.
    #1;
    imem_rdata = 32'h00012083;
    imem_ack = 1'b1;
    tick();
    imem_ack = 1'b0;
    tick();
    tick();
    #1;
    chk("mid_dmem_req", {31'b0, dmem_req}, 32'd1);
    reset = 1'b0;
    #1;
    chk("mid_req_dropped", {31'b0, dmem_req}, 32'd0);
    tick();
    reset = 1'b1;
    dmem_ack = 1'b1;
    #1;
    chk("late_ack_state", {29'b0, state_dbg}, {29'b0, ST_FETCH});
    chk("late_ack_dmem_req", {31'b0, dmem_req}, 32'd0);
    chk("late_ack_pc", pc, 32'h0);
    tick();
    dmem_ack = 1'b0;
    #1;
    chk("late_ack_still_fetch", {29'b0, state_dbg}, {29'b0, ST_FETCH});
    #1;
    run_instr(32'h002081B3, 0, 1'b0, 32'h0, 32'h0);
    chk("restart_latency", retire_cyc, 32'd4);
    chk("restart_pc", pc, 32'h4);
    chk("restart_instret", instret, 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
